// File: rtl/lgu_pkg.sv
// -----------------------------------------------------------------------------
// lgu_pkg
// Shared definitions for the logic-unit arbiter: operation encoding, arbiter
// FSM states, logic-unit shift-select codes, requester identifiers and the
// op -> logic-unit control decode.
// No ports (package).
// -----------------------------------------------------------------------------
package lgu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_NOT = 3'b001,
        OP_SRA = 3'b010,
        OP_SRL = 3'b011,
        OP_SLL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] SHF_SRA  = 2'b00;
    localparam logic [1:0] SHF_SRL  = 2'b01;
    localparam logic [1:0] SHF_SLL  = 2'b10;
    localparam logic [1:0] SHF_ZERO = 2'b11;

    // Requester identity, used for owner and last_grant.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef struct packed {
        logic       and_sel;
        logic       not_sel;
        logic [1:0] shf;
    } lgu_ctl_t;

    // Illegal codes leave every select idle (shf = 11); the unit itself then
    // produces 0 with Z=1, which is passed through untouched.
    function automatic lgu_ctl_t decode_op(input logic [2:0] op);
        lgu_ctl_t c;
        c.and_sel = 1'b0;
        c.not_sel = 1'b0;
        c.shf     = SHF_ZERO;
        case (op)
            OP_AND:  c.and_sel = 1'b1;
            OP_NOT:  c.not_sel = 1'b1;
            OP_SRA:  c.shf     = SHF_SRA;
            OP_SRL:  c.shf     = SHF_SRL;
            OP_SLL:  c.shf     = SHF_SLL;
            default: c.shf     = SHF_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lgu_rr_pick.sv
// -----------------------------------------------------------------------------
// lgu_rr_pick
// Two-input winner select. With a single valid that requester wins; on a tie
// the requester not granted last wins (round-robin).
// Build option: define LGU_ARB_FIXED_PRIO_EN to make A win every tie
// (last_grant ignored, B may starve).
// Ports:
//   valid_a, valid_b  in   request valids
//   last_grant        in   requester granted last (OWN_A / OWN_B)
//   pick_a, pick_b    out  one-hot (or zero) winner, purely combinational
// -----------------------------------------------------------------------------
module lgu_rr_pick
    import lgu_pkg::*;
(
    input  logic valid_a,
    input  logic valid_b,
    input  logic last_grant,
    output logic pick_a,
    output logic pick_b
);

`ifdef LGU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign pick_a = valid_a;
    assign pick_b = valid_b && !valid_a;
`else
    assign pick_a = valid_a && (!valid_b || (last_grant == OWN_B));
    assign pick_b = valid_b && (!valid_a || (last_grant == OWN_A));
`endif

endmodule

// File: rtl/lgu_arbiter.sv
// -----------------------------------------------------------------------------
// lgu_arbiter
// Shares one combinational 16-bit logic/shift unit between requesters A and B.
// One operation in flight: IDLE (accept) -> ISSUE (drive unit one cycle,
// capture result) -> RESP (hold result until owner consumes it).
// Build option: LGU_ARB_FIXED_PRIO_EN (see lgu_rr_pick) selects fixed A-priority.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   reqX_valid/ready/op/in0/in1    request port X (A/B); in1 = shift amount
//   rspX_valid/ready/data/z/n      response port X (A/B)
//   lgu_in0/in1/and/not/shf        drive to the logic unit (ISSUE only)
//   lgu_out/z/n                    result from the logic unit
//   busy                           FSM not in IDLE
//   ops_done                       completed response handshakes (wraps)
// -----------------------------------------------------------------------------
module lgu_arbiter
    import lgu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              reqa_valid,
    output logic              reqa_ready,
    input  logic [2:0]        reqa_op,
    input  logic [DATA_W-1:0] reqa_in0,
    input  logic [DATA_W-1:0] reqa_in1,

    input  logic              reqb_valid,
    output logic              reqb_ready,
    input  logic [2:0]        reqb_op,
    input  logic [DATA_W-1:0] reqb_in0,
    input  logic [DATA_W-1:0] reqb_in1,

    output logic              rspa_valid,
    input  logic              rspa_ready,
    output logic [DATA_W-1:0] rspa_data,
    output logic              rspa_z,
    output logic              rspa_n,

    output logic              rspb_valid,
    input  logic              rspb_ready,
    output logic [DATA_W-1:0] rspb_data,
    output logic              rspb_z,
    output logic              rspb_n,

    output logic [DATA_W-1:0] lgu_in0,
    output logic [DATA_W-1:0] lgu_in1,
    output logic              lgu_and,
    output logic              lgu_not,
    output logic [1:0]        lgu_shf,
    input  logic [DATA_W-1:0] lgu_out,
    input  logic              lgu_z,
    input  logic              lgu_n,

    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    state_e            state;
    state_e            state_d;
    logic              last_grant;
    logic              pick_a;
    logic              pick_b;
    logic              req_fire;
    logic              rsp_fire;

    logic              owner_p0;
    logic [2:0]        op_p0;
    logic [DATA_W-1:0] in0_p0;
    logic [DATA_W-1:0] in1_p0;

    logic [DATA_W-1:0] data_p1;
    logic              z_p1;
    logic              n_p1;

    logic [CNT_W-1:0]  ops_count;
    lgu_ctl_t          ctl;

    lgu_rr_pick u_pick (
        .valid_a    (reqa_valid),
        .valid_b    (reqb_valid),
        .last_grant (last_grant),
        .pick_a     (pick_a),
        .pick_b     (pick_b)
    );

    assign reqa_ready = (state == IDLE) && pick_a;
    assign reqb_ready = (state == IDLE) && pick_b;
    assign req_fire   = (reqa_valid && reqa_ready) || (reqb_valid && reqb_ready);
    assign rsp_fire   = (state == RESP) &&
                        ((owner_p0 == OWN_A) ? rspa_ready : rspb_ready);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_fire) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= OWN_B;
            owner_p0   <= OWN_A;
            ops_count  <= '0;
        end else begin
            state <= state_d;
            if (req_fire) begin
                owner_p0   <= reqb_ready ? OWN_B : OWN_A;
                last_grant <= reqb_ready ? OWN_B : OWN_A;
            end
            if (rsp_fire) begin
                ops_count <= ops_count + 1'b1;
            end
        end
    end

    // ---- p0: request capture (accepted in IDLE) ----
    always_ff @(posedge clk) begin
        if (req_fire) begin
            op_p0  <= reqb_ready ? reqb_op  : reqa_op;
            in0_p0 <= reqb_ready ? reqb_in0 : reqa_in0;
            in1_p0 <= reqb_ready ? reqb_in1 : reqa_in1;
        end
    end

    // ---- ISSUE: drive the logic unit from p0 registers ----
    always_comb begin
        ctl     = decode_op(op_p0);
        lgu_in0 = '0;
        lgu_in1 = '0;
        lgu_and = 1'b0;
        lgu_not = 1'b0;
        lgu_shf = SHF_ZERO;
        if (state == ISSUE) begin
            lgu_in0 = in0_p0;
            lgu_in1 = in1_p0;
            lgu_and = ctl.and_sel;
            lgu_not = ctl.not_sel;
            lgu_shf = ctl.shf;
        end
    end

    // ---- p1: result capture at the end of ISSUE ----
    // Result registers are reset so the response ports read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            z_p1    <= 1'b0;
            n_p1    <= 1'b0;
        end else if (state == ISSUE) begin
            data_p1 <= lgu_out;
            z_p1    <= lgu_z;
            n_p1    <= lgu_n;
        end
    end

    // ---- RESP: present p1 result to the owner only ----
    assign rspa_valid = (state == RESP) && (owner_p0 == OWN_A);
    assign rspb_valid = (state == RESP) && (owner_p0 == OWN_B);
    assign rspa_data  = data_p1;
    assign rspa_z     = z_p1;
    assign rspa_n     = n_p1;
    assign rspb_data  = data_p1;
    assign rspb_z     = z_p1;
    assign rspb_n     = n_p1;

    assign busy     = (state != IDLE);
    assign ops_done = ops_count;

endmodule

// File: tb/tb_lgu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lgu_arbiter
// Directed bench for lgu_arbiter with a behavioural 16-bit logic unit attached.
// Expected responses are queued when stimulus is issued; a monitor pops and
// compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_lgu_arbiter;
    import lgu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        reqa_valid, reqa_ready, reqb_valid, reqb_ready;
    logic [2:0]  reqa_op, reqb_op;
    logic [15:0] reqa_in0, reqa_in1, reqb_in0, reqb_in1;
    logic        rspa_valid, rspa_ready, rspa_z, rspa_n;
    logic        rspb_valid, rspb_ready, rspb_z, rspb_n;
    logic [15:0] rspa_data, rspb_data;
    logic [15:0] lgu_in0, lgu_in1, lgu_out;
    logic        lgu_and, lgu_not, lgu_z, lgu_n;
    logic [1:0]  lgu_shf;
    logic        busy;
    logic [15:0] ops_done;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
        logic        z;
        logic        n;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    lgu_arbiter #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqa_valid(reqa_valid), .reqa_ready(reqa_ready), .reqa_op(reqa_op),
        .reqa_in0(reqa_in0), .reqa_in1(reqa_in1),
        .reqb_valid(reqb_valid), .reqb_ready(reqb_ready), .reqb_op(reqb_op),
        .reqb_in0(reqb_in0), .reqb_in1(reqb_in1),
        .rspa_valid(rspa_valid), .rspa_ready(rspa_ready), .rspa_data(rspa_data),
        .rspa_z(rspa_z), .rspa_n(rspa_n),
        .rspb_valid(rspb_valid), .rspb_ready(rspb_ready), .rspb_data(rspb_data),
        .rspb_z(rspb_z), .rspb_n(rspb_n),
        .lgu_in0(lgu_in0), .lgu_in1(lgu_in1), .lgu_and(lgu_and), .lgu_not(lgu_not),
        .lgu_shf(lgu_shf), .lgu_out(lgu_out), .lgu_z(lgu_z), .lgu_n(lgu_n),
        .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural logic/shift unit.
    logic signed [15:0] sra_src;
    always_comb begin
        sra_src = lgu_in0;
        lgu_out = 16'h0000;
        if (lgu_and)      lgu_out = lgu_in0 & lgu_in1;
        else if (lgu_not) lgu_out = ~lgu_in0;
        else begin
            case (lgu_shf)
                2'b00:   lgu_out = (lgu_in1 >= 16) ? {16{lgu_in0[15]}} : 16'(sra_src >>> lgu_in1[3:0]);
                2'b01:   lgu_out = (lgu_in1 >= 16) ? 16'h0000 : (lgu_in0 >> lgu_in1[3:0]);
                2'b10:   lgu_out = (lgu_in1 >= 16) ? 16'h0000 : (lgu_in0 << lgu_in1[3:0]);
                default: lgu_out = 16'h0000;
            endcase
        end
        lgu_z = (lgu_out == 16'h0000);
        lgu_n = lgu_out[15];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic port, input logic [15:0] data, input logic z, input logic n);
        exp_t e;
        e.port = port;
        e.data = data;
        e.z    = z;
        e.n    = n;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic port, input logic [15:0] data, input logic z, input logic n);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_unexpected: port %0d data %0h with nothing outstanding", port, data);
        end else begin
            e = sb_q.pop_front();
            check("rsp_port", 32'(port), 32'(e.port));
            check("rsp_data", 32'(data), 32'(e.data));
            check("rsp_z",    32'(z),    32'(e.z));
            check("rsp_n",    32'(n),    32'(e.n));
        end
    endtask

    // Monitor: compares on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rspa_valid && rspb_valid) begin
                n_err++;
                $display("FAIL rsp_both_valid: a=%0d b=%0d, expected at most one", rspa_valid, rspb_valid);
            end
            if (rspa_valid && rspa_ready) pop_cmp(1'b0, rspa_data, rspa_z, rspa_n);
            if (rspb_valid && rspb_ready) pop_cmp(1'b1, rspb_data, rspb_z, rspb_n);
        end
    end

    // Requests are presented #1 after a rising edge; each task returns #1
    // after the handshake edge with valid dropped.
    task automatic drive_a(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int t;
        reqa_valid = 1'b1; reqa_op = op; reqa_in0 = a; reqa_in1 = b;
        t = 0;
        do begin @(negedge clk); t++; end while (!reqa_ready && t < 100);
        if (!reqa_ready) begin
            n_cmp++; n_err++;
            $display("FAIL grant_a_timeout: ready=%0d after %0d cycles, expected 1", reqa_ready, t);
        end
        @(posedge clk); #1;
        reqa_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int t;
        reqb_valid = 1'b1; reqb_op = op; reqb_in0 = a; reqb_in1 = b;
        t = 0;
        do begin @(negedge clk); t++; end while (!reqb_ready && t < 100);
        if (!reqb_ready) begin
            n_cmp++; n_err++;
            $display("FAIL grant_b_timeout: ready=%0d after %0d cycles, expected 1", reqb_ready, t);
        end
        @(posedge clk); #1;
        reqb_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_outstanding", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        reqa_valid = 1'b0; reqa_op = 3'b000; reqa_in0 = 16'h0; reqa_in1 = 16'h0;
        reqb_valid = 1'b0; reqb_op = 3'b000; reqb_in0 = 16'h0; reqb_in1 = 16'h0;
        rspa_ready = 1'b1; rspb_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_reqa_ready", 32'(reqa_ready), 32'd0);
        check("rst_rspa_valid", 32'(rspa_valid), 32'd0);
        check("rst_rspb_valid", 32'(rspb_valid), 32'd0);
        check("rst_rsp_data",   32'(rspa_data),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_ops_done",   32'(ops_done),   32'd0);
        check("rst_lgu_in0",    32'(lgu_in0),    32'd0);
        check("rst_lgu_and",    32'(lgu_and),    32'd0);
        check("rst_lgu_shf",    32'(lgu_shf),    32'd3);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // A only: AND, response at cycle 2
        push_exp(1'b0, 16'h00F0, 1'b0, 1'b0);
        drive_a(OP_AND, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        check("and_issue_busy",    32'(busy),       32'd1);
        check("and_issue_lgu_and", 32'(lgu_and),    32'd1);
        check("and_issue_lgu_in0", 32'(lgu_in0),    32'hF0F0);
        check("and_issue_lgu_in1", 32'(lgu_in1),    32'h0FF0);
        check("and_issue_rspa_vld",32'(rspa_valid), 32'd0);
        @(negedge clk);
        check("and_c2_rspa_valid", 32'(rspa_valid), 32'd1);
        check("and_c2_rspb_valid", 32'(rspb_valid), 32'd0);
        wait_drain();
        check("ops_done_1", 32'(ops_done), 32'd1);

        // B only: SRA then SRL of 8000 by 4
        push_exp(1'b1, 16'hF800, 1'b0, 1'b1);
        drive_b(OP_SRA, 16'h8000, 16'd4);
        @(negedge clk);
        check("sra_lgu_shf", 32'(lgu_shf), 32'd0);
        wait_drain();
        push_exp(1'b1, 16'h0800, 1'b0, 1'b0);
        drive_b(OP_SRL, 16'h8000, 16'd4);
        @(negedge clk);
        check("srl_lgu_shf", 32'(lgu_shf), 32'd1);
        wait_drain();
        check("ops_done_3", 32'(ops_done), 32'd3);

        // Both valid continuously, 4 ops each; last grant was B so A leads.
`ifdef LGU_ARB_FIXED_PRIO_EN
        push_exp(1'b0, 16'h1234, 1'b0, 1'b0);
        push_exp(1'b0, 16'h0010, 1'b0, 1'b0);
        push_exp(1'b0, 16'h0001, 1'b0, 1'b0);
        push_exp(1'b0, 16'hFFFF, 1'b0, 1'b1);
        push_exp(1'b1, 16'h2000, 1'b0, 1'b0);
        push_exp(1'b1, 16'hFF00, 1'b0, 1'b1);
        push_exp(1'b1, 16'h0000, 1'b1, 1'b0);
        push_exp(1'b1, 16'hFFFF, 1'b0, 1'b1);
`else
        push_exp(1'b0, 16'h1234, 1'b0, 1'b0);
        push_exp(1'b1, 16'h2000, 1'b0, 1'b0);
        push_exp(1'b0, 16'h0010, 1'b0, 1'b0);
        push_exp(1'b1, 16'hFF00, 1'b0, 1'b1);
        push_exp(1'b0, 16'h0001, 1'b0, 1'b0);
        push_exp(1'b1, 16'h0000, 1'b1, 1'b0);
        push_exp(1'b0, 16'hFFFF, 1'b0, 1'b1);
        push_exp(1'b1, 16'hFFFF, 1'b0, 1'b1);
`endif
        fork
            begin
                drive_a(OP_AND, 16'hFFFF, 16'h1234);
                drive_a(OP_SLL, 16'h0001, 16'd4);
                drive_a(OP_SRL, 16'h8000, 16'd15);
                drive_a(OP_NOT, 16'h0000, 16'h0000);
            end
            begin
                drive_b(OP_SRA, 16'h4000, 16'd1);
                drive_b(OP_NOT, 16'h00FF, 16'h0000);
                drive_b(OP_AND, 16'hAAAA, 16'h5555);
                drive_b(OP_SRA, 16'h8000, 16'd20);
            end
        join
        wait_drain();
        check("ops_done_11", 32'(ops_done), 32'd11);

        // Response stall on A; B must not be accepted meanwhile.
        push_exp(1'b0, 16'h8000, 1'b0, 1'b1);
        push_exp(1'b1, 16'hFFFF, 1'b0, 1'b1);
        rspa_ready = 1'b0;
        drive_a(OP_SLL, 16'h0001, 16'd15);
        fork
            drive_b(OP_AND, 16'hFFFF, 16'hFFFF);
            begin
                for (int i = 1; i <= 6; i++) begin
                    @(negedge clk);
                    check("stall_reqb_ready", 32'(reqb_ready), 32'd0);
                    if (i >= 2) begin
                        check("stall_rspa_valid", 32'(rspa_valid), 32'd1);
                        check("stall_rspa_data",  32'(rspa_data),  32'h8000);
                    end
                end
                @(posedge clk); #1;
                rspa_ready = 1'b1;
            end
        join
        wait_drain();
        check("ops_done_13", 32'(ops_done), 32'd13);

        // Illegal op and NOT of all-ones both yield 0 with Z set.
        push_exp(1'b0, 16'h0000, 1'b1, 1'b0);
        drive_a(3'b111, 16'h1234, 16'h5678);
        @(negedge clk);
        check("ill_lgu_shf", 32'(lgu_shf), 32'd3);
        check("ill_lgu_and", 32'(lgu_and), 32'd0);
        check("ill_lgu_not", 32'(lgu_not), 32'd0);
        wait_drain();
        push_exp(1'b1, 16'h0000, 1'b1, 1'b0);
        drive_b(OP_NOT, 16'hFFFF, 16'h0000);
        @(negedge clk);
        check("not_lgu_not", 32'(lgu_not), 32'd1);
        wait_drain();
        check("ops_done_15", 32'(ops_done), 32'd15);

        // Reset during ISSUE drops the operation.
        drive_a(OP_AND, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        check("rsti_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rsti_busy",       32'(busy),       32'd0);
        check("rsti_rspa_valid", 32'(rspa_valid), 32'd0);
        check("rsti_lgu_in0",    32'(lgu_in0),    32'd0);
        check("rsti_lgu_in1",    32'(lgu_in1),    32'd0);
        check("rsti_lgu_and",    32'(lgu_and),    32'd0);
        check("rsti_lgu_not",    32'(lgu_not),    32'd0);
        check("rsti_lgu_shf",    32'(lgu_shf),    32'd3);
        check("rsti_ops_done",   32'(ops_done),   32'd0);
        check("rsti_rsp_data",   32'(rspa_data),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rsti_no_rsp", 32'(rspa_valid | rspb_valid), 32'd0);
        @(posedge clk); #1;
        push_exp(1'b0, 16'h00F0, 1'b0, 1'b0);
        drive_a(OP_AND, 16'hF0F0, 16'h0FF0);
        wait_drain();
        check("rsti_ops_done_1", 32'(ops_done), 32'd1);
        push_exp(1'b1, 16'h0000, 1'b1, 1'b0);
        drive_b(OP_SLL, 16'h0003, 16'd16);
        wait_drain();
        check("rsti_ops_done_2", 32'(ops_done), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
